mix_columns_seq: RTL and testbench
==================================

Name: mix_columns_seq

Overview:
Sequential AES MixColumns / InvMixColumns engine. It accepts a 128-bit state through a valid/ready handshake and processes COLS_PER_CYCLE columns per clock, using GF(2^8) multiplication modulo x^8+x^4+x^3+x+1 (0x11B). It returns the transformed state through a valid/ready handshake. It sits downstream of ShiftRows in the round datapath and consumes the team's GF multiplier.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4; compute latency NCYC = 4/COLS_PER_CYCLE.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input state is valid
in_ready  output  1  engine can accept a state
in_inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled at acceptance
in_state  input  128  state; byte k = in_state[127-8k -: 8], column c = bytes 4c..4c+3, row r = byte 4c+r
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_state  output  128  transformed state, same byte order as in_state
busy  output  1  high in BUSY or DONE

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low; clock and reset ports are clk and rst_n.
- States: IDLE, BUSY, DONE. Column counter col is 2 bits wide.
- Reset, asynchronous, also mid-operation:
  - state returns to IDLE; col = 0.
  - out_valid = 0; out_state = 0; busy = 0; in_ready = 1 one combinational step after state = IDLE.
  - The captured mode and working register are cleared to 0.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture in_state into the working register, capture in_inv, set col = 0, go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each edge replaces columns col .. col+COLS_PER_CYCLE-1 of the working register with their transform; col += COLS_PER_CYCLE.
  - On the edge that finishes column 3: go to DONE and set out_valid = 1. This occurs exactly NCYC edges after the accept edge.
- DONE:
  - out_valid = 1; out_state = working register, held stable while out_ready = 0.
  - On out_valid && out_ready: out_valid = 0 and go to IDLE.
  - in_ready stays 0 in DONE, so no new state is accepted in the same cycle. Minimum issue interval is NCYC+2 cycles.
- in_valid, in_state and in_inv are ignored outside IDLE. in_state may change freely after the accept edge.
- Column transform, for input column a0..a3 producing b0..b3 (all arithmetic in GF(2^8); + is XOR):
  - Forward: b0 = 02·a0+03·a1+a2+a3; b1 = a0+02·a1+03·a2+a3; b2 = a0+a1+02·a2+03·a3; b3 = 03·a0+a1+a2+02·a3.
  - Inverse: circulant rows {0E,0B,0D,09}, i.e. b0 = 0E·a0+0B·a1+0D·a2+09·a3, with each following row rotated right by one.
- xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0), with the result truncated to 8 bits. Constant multiplies are built from xtime chains or from GF multiplier instances; both give bit-identical results.
- out_state changes only on the edge entering DONE, or on reset.
- A COLS_PER_CYCLE value other than 1, 2 or 4 is a configuration error, flagged by an elaboration-time check.

Test Plan:
1. Single column, forward: column 0 = db 13 53 45, other columns 01 01 01 01, in_inv=0 -> out_state column 0 = 8e 4d a1 bc, other columns 01 01 01 01. out_valid rises exactly NCYC edges after accept.
2. FIPS-197 round 1, forward: in_state = d4bf5d30 e0b452ae b84111f1 1e2798e5 -> out_state = 046681e5 e0cb199a 48f8d37a 2806264c.
3. Inverse round trip: feed 046681e5 e0cb199a 48f8d37a 2806264c with in_inv=1 -> d4bf5d30 e0b452ae b84111f1 1e2798e5. Also check columns f2 0a 22 5c <-> 9f dc 58 9d and c6 c6 c6 c6 -> c6 c6 c6 c6.
4. Backpressure:
   - Hold out_ready = 0 for 10 cycles in DONE -> out_state stable and in_ready = 0 throughout.
   - Assert in_valid with a new state during BUSY -> it is not accepted.
   - Release out_ready -> next edge is IDLE and in_ready = 1.
5. Reset mid-operation: drop rst_n asynchronously two cycles after accept -> out_valid, busy and out_state go to 0 immediately. After release, a fresh transaction gives the correct result.
6. Parameter sweep: repeat scenarios 1-3 with COLS_PER_CYCLE = 1, 2, 4 -> identical results; latency 4, 2 and 1 edges respectively. Back-to-back streams of 100 random states match a software model in both modes.

Source files
------------

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the MixColumns engine: input state channel and result channel.
interface mix_columns_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic         in_inv;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   modport slave (
      input  in_valid, in_inv, in_state, out_ready,
      output in_ready, out_valid, out_state
   );

   modport master (
      output in_valid, in_inv, in_state, out_ready,
      input  in_ready, out_valid, out_state
   );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns: COLS_PER_CYCLE columns per BUSY cycle,
// result held in a dedicated output register until the consumer takes it.
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   mix_columns_seq_if.slave   bus,
   output logic               busy
);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
         $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [1:0]     col_q, col_d;
   logic           inv_q, inv_d;
   logic [127:0]   work_q, work_d;
   logic [127:0]   out_q, out_d;
   logic           out_valid_q, out_valid_d;
   logic [1:0]     idx_s;
   logic [6:0]     base_s;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // One column through the forward or inverse circulant matrix; a0 is the top byte.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0] a [4];
      logic [7:0] m2 [4];
      logic [7:0] m3 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x4;
      logic [7:0] x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         m2[i] = xtime(a[i]);
         m3[i] = m2[i] ^ a[i];
         x4    = xtime(m2[i]);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ m2[i] ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ m2[i];
      end
      if (inv) begin
         return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};
      end else begin
         return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
                 a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                 a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                 m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
      end
   endfunction

   // Next-state logic: accept in IDLE, transform columns in BUSY, hold result in DONE.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      inv_d       = inv_q;
      work_d      = work_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      idx_s       = 2'd0;
      base_s      = 7'd0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               work_d  = bus.in_state;
               inv_d   = bus.in_inv;
               col_d   = 2'd0;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
               idx_s  = col_q + 2'(j);
               base_s = 7'd96 - {idx_s, 5'd0};
               work_d[base_s +: 32] = mix_col(work_q[base_s +: 32], inv_q);
            end
            col_d = col_q + COL_STEP;
            if (col_q == LAST_COL) begin
               out_d       = work_d;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset clears mode, working and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         col_q       <= 2'd0;
         inv_q       <= 1'b0;
         work_q      <= 128'd0;
         out_q       <= 128'd0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         inv_q       <= inv_d;
         work_q      <= work_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_state = out_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and random checks of mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4 side by side.
module tb_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid_a  [3];
   logic         in_inv_a    [3];
   logic [127:0] in_state_a  [3];
   logic         out_ready_a [3];
   logic         in_ready_a  [3];
   logic         out_valid_a [3];
   logic [127:0] out_state_a [3];
   logic         busy_a      [3];
   int           n_assert = 0;
   int           n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_seq_if u_if ();
      assign u_if.in_valid  = in_valid_a[g];
      assign u_if.in_inv    = in_inv_a[g];
      assign u_if.in_state  = in_state_a[g];
      assign u_if.out_ready = out_ready_a[g];
      assign in_ready_a[g]  = u_if.in_ready;
      assign out_valid_a[g] = u_if.out_valid;
      assign out_state_a[g] = u_if.out_state;
      mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (u_if.slave),
         .busy  (busy_a[g])
      );
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'd0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] model_mix(input logic [127:0] st, input logic inv);
      logic [7:0]   cf [4];
      logic [7:0]   acc;
      logic [127:0] res;
      if (inv) begin
         cf[0] = 8'h0E; cf[1] = 8'h0B; cf[2] = 8'h0D; cf[3] = 8'h09;
      end else begin
         cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
      end
      res = 128'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gmul(cf[(k - r + 4) % 4], st[127 - 8*(4*c + k) -: 8]);
            res[127 - 8*(4*c + r) -: 8] = acc;
         end
      end
      return res;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full transaction on DUT d: accept, measure latency, check result, hand it off.
   task automatic txn(input int d, input logic inv, input logic [127:0] st,
                      input logic [127:0] exp, input string tag);
      int lat;
      @(negedge clk);
      check($sformatf("%s_d%0d_in_ready", tag, d), 128'(in_ready_a[d]), 128'd1);
      in_valid_a[d] = 1'b1;
      in_inv_a[d]   = inv;
      in_state_a[d] = st;
      @(posedge clk);
      #1;
      in_valid_a[d] = 1'b0;
      in_inv_a[d]   = ~inv;
      in_state_a[d] = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid_a[d] && lat < 20);
      check($sformatf("%s_d%0d_latency", tag, d), 128'(lat), 128'(4 >> d));
      check($sformatf("%s_d%0d_state", tag, d), out_state_a[d], exp);
      out_ready_a[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_a[d] = 1'b0;
      @(negedge clk);
      check($sformatf("%s_d%0d_released", tag, d),
            128'({out_valid_a[d], in_ready_a[d], busy_a[d]}), 128'(3'b010));
   endtask

   localparam logic [127:0] T1_IN  = 128'hdb135345_01010101_01010101_01010101;
   localparam logic [127:0] T1_OUT = 128'h8e4da1bc_01010101_01010101_01010101;
   localparam logic [127:0] R1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
   localparam logic [127:0] R1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
   localparam logic [127:0] M_IN   = 128'hf20a225c_c6c6c6c6_01010101_db135345;
   localparam logic [127:0] M_OUT  = 128'h9fdc589d_c6c6c6c6_01010101_8e4da1bc;

   initial begin
      logic [127:0] st;
      logic         inv;
      for (int d = 0; d < 3; d++) begin
         in_valid_a[d]  = 1'b0;
         in_inv_a[d]    = 1'b0;
         in_state_a[d]  = 128'd0;
         out_ready_a[d] = 1'b0;
      end
      #12;
      for (int d = 0; d < 3; d++)
         check($sformatf("reset_d%0d", d),
               {out_state_a[d][123:0], out_valid_a[d], busy_a[d], in_ready_a[d]},
               {124'd0, 3'b001});
      @(negedge clk);
      rst_n = 1'b1;

      for (int d = 0; d < 3; d++) begin
         txn(d, 1'b0, T1_IN,  T1_OUT, "single_col");
         txn(d, 1'b0, R1_IN,  R1_OUT, "fips_fwd");
         txn(d, 1'b1, R1_OUT, R1_IN,  "fips_inv");
         txn(d, 1'b0, M_IN,   M_OUT,  "mixed_fwd");
         txn(d, 1'b1, M_OUT,  M_IN,   "mixed_inv");
      end

      // Backpressure on the single-column engine, with a competing state offered while busy.
      @(negedge clk);
      in_valid_a[0] = 1'b1;
      in_inv_a[0]   = 1'b0;
      in_state_a[0] = R1_IN;
      @(posedge clk);
      #1;
      in_state_a[0] = T1_IN;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid_a[0]) break;
         check("bp_busy_in_ready", 128'(in_ready_a[0]), 128'd0);
      end
      for (int i = 0; i < 10; i++) begin
         check("bp_hold_state", out_state_a[0], R1_OUT);
         check("bp_hold_flags", 128'({out_valid_a[0], in_ready_a[0], busy_a[0]}), 128'(3'b101));
         @(negedge clk);
      end
      in_valid_a[0]  = 1'b0;
      out_ready_a[0] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_a[0] = 1'b0;
      @(negedge clk);
      check("bp_release", 128'({out_valid_a[0], in_ready_a[0], busy_a[0]}), 128'(3'b010));

      // Asynchronous reset two cycles into a transaction.
      @(negedge clk);
      in_valid_a[0] = 1'b1;
      in_state_a[0] = T1_IN;
      @(posedge clk);
      #1;
      in_valid_a[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("rst_pre_busy", 128'({busy_a[0], out_state_a[0] != 128'd0}), 128'(2'b11));
      rst_n = 1'b0;
      #1;
      check("rst_mid_state", out_state_a[0], 128'd0);
      check("rst_mid_flags", 128'({out_valid_a[0], busy_a[0], in_ready_a[0]}), 128'(3'b001));
      @(negedge clk);
      rst_n = 1'b1;
      txn(0, 1'b0, R1_IN, R1_OUT, "post_rst");

      // Back-to-back random streams against the software model in both modes.
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 100; n++) begin
            st  = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(1, 0));
            txn(d, inv, st, model_mix(st, inv), "rnd");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
